// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pq_pkg
// Description : Shared cell and operation types for the array priority queue
//               and its consumer-side dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package pq_pkg;

    localparam int TIME_W    = 27;
    localparam int PAYLOAD_W = 8;

    // data carries the due timestamp, id identifies the cell for DROP.
    typedef struct packed {
        logic [TIME_W-1:0]    data;
        logic [TIME_W-1:0]    id;
        logic [PAYLOAD_W-1:0] payload;
    } cell_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_DROP = 2'd3
    } op_t;

endpackage
`default_nettype wire

// File: rtl/pq_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : pq_dispatcher_if
// Description : Bundles the queue, host-drop, downstream and statistics
//               signals of the dispatcher. slave = dispatcher side,
//               master = the environment driving it.
// Revision    : 1.0 - initial release
// ============================================================================
interface pq_dispatcher_if #(
    parameter int TIME_WIDTH = pq_pkg::TIME_W,
    parameter int STAT_WIDTH = 16
);
    logic                  tick_i;
    logic [TIME_WIDTH-1:0] now_o;
    pq_pkg::cell_t         pq_head_i;
    logic                  pq_empty_i;
    logic                  pq_ready_i;
    pq_pkg::op_t           pq_op_o;
    logic [TIME_WIDTH-1:0] pq_id_o;
    logic                  drop_valid_i;
    logic [TIME_WIDTH-1:0] drop_id_i;
    logic                  drop_ready_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    pq_pkg::cell_t         out_cell_o;
    logic                  late_o;
    logic [STAT_WIDTH-1:0] disp_cnt_o;
    logic [STAT_WIDTH-1:0] late_cnt_o;

    modport slave (
        input  tick_i, pq_head_i, pq_empty_i, pq_ready_i,
               drop_valid_i, drop_id_i, out_ready_i,
        output now_o, pq_op_o, pq_id_o, drop_ready_o,
               out_valid_o, out_cell_o, late_o, disp_cnt_o, late_cnt_o
    );

    modport master (
        output tick_i, pq_head_i, pq_empty_i, pq_ready_i,
               drop_valid_i, drop_id_i, out_ready_i,
        input  now_o, pq_op_o, pq_id_o, drop_ready_o,
               out_valid_o, out_cell_o, late_o, disp_cnt_o, late_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : pq_dispatcher
// Description : Consumer front end of the priority queue. Runs a time base,
//               pops the head once its timestamp is due (wrap-aware), holds
//               it on a valid/ready port, forwards host drop requests as
//               DROP ops and counts dispatched / late cells.
// Revision    : 1.0 - initial release
// ============================================================================
module pq_dispatcher #(
    parameter int TIME_WIDTH    = pq_pkg::TIME_W,
    parameter int PAYLOAD_WIDTH = pq_pkg::PAYLOAD_W,
    parameter int DELTA_MAX     = 20,
    parameter int STAT_WIDTH    = 16
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    pq_dispatcher_if.slave bus
);
    import pq_pkg::*;

    // The cell layout comes from the package; a mismatched override would
    // silently truncate timestamps, so refuse to elaborate.
    generate
        if (TIME_WIDTH != TIME_W || PAYLOAD_WIDTH != PAYLOAD_W) begin : g_width_check
            $error("pq_dispatcher: widths must match pq_pkg cell_t");
        end
    endgenerate

    localparam logic [TIME_WIDTH-1:0] C_DELTA_MAX = TIME_WIDTH'(DELTA_MAX);
    localparam logic [STAT_WIDTH-1:0] C_STAT_ONE  = STAT_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [TIME_WIDTH-1:0] r_now;
    cell_t                 r_cell;
    logic                  r_late;
    logic [STAT_WIDTH-1:0] r_disp_cnt;
    logic [STAT_WIDTH-1:0] r_late_cnt;

    logic [TIME_WIDTH-1:0] w_diff;
    logic                  w_due;
    logic                  w_pop_acc;
    logic                  w_hs;

    // Modular distance from head timestamp to now; MSB set means "future".
    assign w_diff = r_now - bus.pq_head_i.data;
    assign w_due  = !bus.pq_empty_i && !w_diff[TIME_WIDTH-1];
    assign w_hs   = (r_state == ST_HOLD) && bus.out_ready_i;

    // One queue op per cycle: host drop wins, else POP a due head when idle.
    always_comb begin
        bus.pq_op_o      = OP_NOP;
        bus.pq_id_o      = '0;
        bus.drop_ready_o = 1'b0;
        w_pop_acc        = 1'b0;
        if (bus.drop_valid_i) begin
            bus.pq_op_o      = OP_DROP;
            bus.pq_id_o      = bus.drop_id_i;
            bus.drop_ready_o = bus.pq_ready_i;
        end else if (r_state == ST_IDLE && w_due) begin
            bus.pq_op_o = OP_POP;
            w_pop_acc   = bus.pq_ready_i;
        end
    end

    // Free-running time base, advanced by tick_i, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_now <= '0;
        end else if (bus.tick_i) begin
            r_now <= r_now + TIME_WIDTH'(1);
        end
    end

    // Output buffer FSM with saturating dispatch/late statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cell     <= '0;
            r_late     <= 1'b0;
            r_disp_cnt <= '0;
            r_late_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop_acc) begin
                        r_cell  <= bus.pq_head_i;
                        r_late  <= (w_diff > C_DELTA_MAX);
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_hs) begin
                        if (r_disp_cnt != '1) begin
                            r_disp_cnt <= r_disp_cnt + C_STAT_ONE;
                        end
                        if (r_late && r_late_cnt != '1) begin
                            r_late_cnt <= r_late_cnt + C_STAT_ONE;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.now_o       = r_now;
    assign bus.out_valid_o = (r_state == ST_HOLD);
    assign bus.out_cell_o  = r_cell;
    assign bus.late_o      = r_late;
    assign bus.disp_cnt_o  = r_disp_cnt;
    assign bus.late_cnt_o  = r_late_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pq_dispatcher
// Description : Directed self-checking bench for pq_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pq_dispatcher;
    import pq_pkg::*;

    localparam int TW = 27;
    localparam int SW = 16;
    localparam logic [TW-1:0] C_MAXT = {TW{1'b1}};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    pq_dispatcher_if #(.TIME_WIDTH(TW), .STAT_WIDTH(SW)) bus ();

    pq_dispatcher #(
        .TIME_WIDTH    (TW),
        .PAYLOAD_WIDTH (8),
        .DELTA_MAX     (20),
        .STAT_WIDTH    (SW)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic cell_t mk(input logic [TW-1:0] d, input logic [TW-1:0] id,
                                 input logic [7:0] p);
        cell_t c;
        c.data    = d;
        c.id      = id;
        c.payload = p;
        return c;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tick_i       = 1'b0;
        bus.pq_head_i    = '0;
        bus.pq_empty_i   = 1'b1;
        bus.pq_ready_i   = 1'b0;
        bus.drop_valid_i = 1'b0;
        bus.drop_id_i    = '0;
        bus.out_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    // Pop a head with timestamp data once now reaches pop_at; check lateness.
    task automatic late_case(input string tag, input logic [TW-1:0] data,
                             input int pop_at, input logic exp_late);
        do_reset();
        bus.pq_head_i  = mk(data, 27'd1, 8'h55);
        bus.pq_empty_i = 1'b0;
        bus.tick_i     = 1'b1;
        repeat (pop_at) step();
        chk({tag, "_now"}, bus.now_o, pop_at);
        chk({tag, "_novld"}, bus.out_valid_o, 1'b0);
        bus.pq_ready_i = 1'b1;
        #1;
        chk({tag, "_op"}, bus.pq_op_o, OP_POP);
        step();
        bus.pq_empty_i = 1'b1;
        bus.pq_ready_i = 1'b0;
        chk({tag, "_vld"}, bus.out_valid_o, 1'b1);
        chk({tag, "_late"}, bus.late_o, exp_late);
        bus.out_ready_i = 1'b1;
        step();
        chk({tag, "_lcnt"}, bus.late_cnt_o, exp_late);
        chk({tag, "_dcnt"}, bus.disp_cnt_o, 1);
    endtask

    initial begin
        idle_inputs();
        step();
        step();
        // Reset state
        chk("rst_now", bus.now_o, 0);
        chk("rst_vld", bus.out_valid_o, 1'b0);
        chk("rst_cell", bus.out_cell_o, 0);
        chk("rst_late", bus.late_o, 1'b0);
        chk("rst_op", bus.pq_op_o, OP_NOP);
        chk("rst_id", bus.pq_id_o, 0);
        chk("rst_drdy", bus.drop_ready_o, 1'b0);
        chk("rst_dcnt", bus.disp_cnt_o, 0);
        chk("rst_lcnt", bus.late_cnt_o, 0);
        rst_ni = 1'b1;

        // Empty queue, ten ticks
        bus.tick_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("empty_op", bus.pq_op_o, OP_NOP);
            chk("empty_vld", bus.out_valid_o, 1'b0);
            step();
        end
        chk("empty_now", bus.now_o, 10);

        // On-time dispatch of head data=5
        do_reset();
        bus.pq_head_i   = mk(27'd5, 27'd3, 8'hA5);
        bus.pq_empty_i  = 1'b0;
        bus.pq_ready_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        bus.tick_i      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("ot_now", bus.now_o, c);
            chk("ot_op", bus.pq_op_o, (c == 5) ? OP_POP : OP_NOP);
            step();
        end
        bus.pq_empty_i = 1'b1;
        #1;
        chk("ot_vld", bus.out_valid_o, 1'b1);
        chk("ot_cell", bus.out_cell_o, mk(27'd5, 27'd3, 8'hA5));
        chk("ot_late", bus.late_o, 1'b0);
        chk("ot_dcnt0", bus.disp_cnt_o, 0);
        step();
        chk("ot_dcnt1", bus.disp_cnt_o, 1);
        chk("ot_vld0", bus.out_valid_o, 1'b0);
        chk("ot_lcnt", bus.late_cnt_o, 0);

        // Lateness: diff 25, and the DELTA_MAX boundary 20 / 21
        late_case("late25", 27'd5, 30, 1'b1);
        late_case("late20", 27'd0, 20, 1'b0);
        late_case("late21", 27'd0, 21, 1'b1);

        // Drop priority over a due POP
        do_reset();
        bus.pq_head_i    = mk(27'd0, 27'd4, 8'h11);
        bus.pq_empty_i   = 1'b0;
        bus.drop_valid_i = 1'b1;
        bus.drop_id_i    = 27'd7;
        #1;
        chk("drop_op_nr", bus.pq_op_o, OP_DROP);
        chk("drop_rdy_nr", bus.drop_ready_o, 1'b0);
        step();
        chk("drop_defer", bus.out_valid_o, 1'b0);
        bus.pq_ready_i = 1'b1;
        #1;
        chk("drop_op", bus.pq_op_o, OP_DROP);
        chk("drop_id", bus.pq_id_o, 7);
        chk("drop_rdy", bus.drop_ready_o, 1'b1);
        step();
        chk("drop_novld", bus.out_valid_o, 1'b0);
        bus.drop_valid_i = 1'b0;
        #1;
        chk("drop_pop", bus.pq_op_o, OP_POP);
        chk("drop_pid", bus.pq_id_o, 0);
        step();
        chk("drop_vld", bus.out_valid_o, 1'b1);

        // Stall in HOLD with a second head due; drop still served
        bus.pq_head_i = mk(27'd0, 27'd9, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_op", bus.pq_op_o, OP_NOP);
            chk("hold_cell", bus.out_cell_o, mk(27'd0, 27'd4, 8'h11));
            step();
        end
        bus.drop_valid_i = 1'b1;
        bus.drop_id_i    = 27'd2;
        #1;
        chk("hold_drop", bus.pq_op_o, OP_DROP);
        chk("hold_drdy", bus.drop_ready_o, 1'b1);
        step();
        bus.drop_valid_i = 1'b0;
        bus.out_ready_i  = 1'b1;
        #1;
        chk("hs_op", bus.pq_op_o, OP_NOP);
        step();
        bus.out_ready_i = 1'b0;
        #1;
        chk("bub_vld", bus.out_valid_o, 1'b0);
        chk("bub_dcnt", bus.disp_cnt_o, 1);
        chk("bub_op", bus.pq_op_o, OP_POP);
        step();
        chk("pop2_vld", bus.out_valid_o, 1'b1);
        chk("pop2_cell", bus.out_cell_o, mk(27'd0, 27'd9, 8'h3C));

        // Asynchronous reset in HOLD discards the buffered cell
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_vld", bus.out_valid_o, 1'b0);
        chk("arst_cell", bus.out_cell_o, 0);
        chk("arst_dcnt", bus.disp_cnt_o, 0);

        // Wrap-aware due test at now=1
        do_reset();
        bus.tick_i = 1'b1;
        step();
        bus.tick_i = 1'b0;
        chk("wr_now", bus.now_o, 1);
        bus.pq_empty_i = 1'b0;
        bus.pq_head_i  = mk(C_MAXT - 27'd1, 27'd5, 8'h77);
        #1;
        chk("wr_due", bus.pq_op_o, OP_POP);
        bus.pq_head_i = mk(C_MAXT, 27'd5, 8'h77);
        #1;
        chk("wr_due_max", bus.pq_op_o, OP_POP);
        bus.pq_head_i = mk(27'd100, 27'd6, 8'h77);
        #1;
        chk("wr_future", bus.pq_op_o, OP_NOP);
        bus.pq_head_i = mk(27'h400_0001, 27'd6, 8'h77);
        #1;
        chk("wr_halfpast", bus.pq_op_o, OP_NOP);
        bus.pq_head_i = mk(27'h400_0002, 27'd6, 8'h77);
        #1;
        chk("wr_justdue", bus.pq_op_o, OP_POP);
        bus.pq_empty_i = 1'b1;
        #1;
        chk("wr_empty", bus.pq_op_o, OP_NOP);
        bus.pq_empty_i = 1'b0;
        bus.pq_head_i  = mk(C_MAXT - 27'd1, 27'd5, 8'h77);
        bus.pq_ready_i = 1'b1;
        step();
        bus.pq_ready_i = 1'b0;
        chk("wr_vld", bus.out_valid_o, 1'b1);
        chk("wr_cell", bus.out_cell_o, mk(C_MAXT - 27'd1, 27'd5, 8'h77));
        chk("wr_late", bus.late_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pq_dispatcher.md
# pq_dispatcher

Consumer-side front end for the array priority queue. It keeps a free-running time base and compares it with the queue head's timestamp. When the head is due, it issues POP and forwards the popped cell downstream over a valid/ready port. It also converts host drop-by-id requests into queue DROP operations and counts dispatched and late cells.

## Interface
Parameters:
- TIME_WIDTH, 27: timestamp/id width; time base wraps at 2**TIME_WIDTH.
- PAYLOAD_WIDTH, 8: payload width (cell_t from pq_pkg).
- DELTA_MAX, 20: lateness threshold in ticks for late counting.
- STAT_WIDTH, 16: width of statistics counters.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tick_i  in  1  time-base advance enable.
- now_o  out  TIME_WIDTH  current time base.
- pq_head_i  in  cell_t  queue head cell (combinational from queue).
- pq_empty_i  in  1  queue empty.
- pq_ready_i  in  1  queue accepts an op this cycle.
- pq_op_o  out  op_t  op to queue (PUSH never issued).
- pq_id_o  out  TIME_WIDTH  id operand for DROP.
- drop_valid_i  in  1  host drop request.
- drop_id_i  in  TIME_WIDTH  id to drop.
- drop_ready_o  out  1  drop request accepted this cycle.
- out_valid_o  out  1  dispatched cell valid.
- out_ready_i  in  1  downstream accepts cell.
- out_cell_o  out  cell_t  dispatched cell.
- late_o  out  1  out_cell_o was dispatched more than DELTA_MAX ticks after its timestamp.
- disp_cnt_o  out  STAT_WIDTH  cells dispatched (handshake completed).
- late_cnt_o  out  STAT_WIDTH  late cells dispatched.

## Operation
- The time base now increments by 1 on each tick_i cycle, modulo 2**TIME_WIDTH.
- Due test, wrap-aware: diff = (now - pq_head_i.data) mod 2**TIME_WIDTH. The head is due iff !pq_empty_i and diff[TIME_WIDTH-1]==0.
- FSM states:
  - IDLE: output buffer empty.
  - HOLD: cell buffered, out_valid_o=1.
- Op selection is combinational, one op per cycle. The op counts as accepted when pq_ready_i=1.
  - drop_valid_i has priority. pq_op_o=DROP, pq_id_o=drop_id_i, drop_ready_o=pq_ready_i. Allowed in IDLE and HOLD.
  - Otherwise, in IDLE with the head due: pq_op_o=POP. On acceptance, capture pq_head_i into out_cell_o, set late = (diff > DELTA_MAX), and go to HOLD.
  - Otherwise pq_op_o=NOP.
- HOLD: when out_valid_o and out_ready_i, increment disp_cnt_o, and increment late_cnt_o if late_o. Then return to IDLE.
- No POP is issued in HOLD. One bubble cycle follows each handshake before the next POP.
- Counters saturate at all-ones.
- pq_id_o = 0 when op is not DROP.
- While DROP is chosen and pq_ready_i=0, drop_ready_o=0. The host holds the request, and a due POP is deferred.

## Timing
- Reset (async assert, sync deassert by design convention) sets:
  - now_o=0, state IDLE, out_valid_o=0, out_cell_o=0, late_o=0, pq_op_o=NOP, pq_id_o=0, drop_ready_o=0, both counters=0.
- Latency:
  - The head becomes due at cycle t. POP is presented combinationally in cycle t if pq_ready_i and no drop.
  - out_valid_o rises at t+1.
- The next POP is possible at the earliest in the cycle after the output handshake.
- The due test uses now_o as registered, i.e. the value before this cycle's tick.
- Wrap-around: head.data=2**27-2 with now=1 gives diff=3, so the head is due.
- Head timestamps more than 2**(TIME_WIDTH-1) in the past are treated as future. This is a documented limitation.
- out_cell_o and late_o are stable while out_valid_o=1 and !out_ready_i.
- Reset mid-HOLD discards the buffered cell; it is not re-queued.

## Test plan
- Reset then 10 ticks with the queue empty -> now_o=10, pq_op_o=NOP throughout, out_valid_o=0.
- Head {data=5,id=3,payload=0xA5} with tick every cycle -> POP in the cycle now_o==5. Next cycle out_valid_o=1, out_cell_o.payload=0xA5, late_o=0. With out_ready_i=1, disp_cnt_o=1.
- Head data=5, tick_i held low until now=0 then raised, pq_ready_i low until now=30 -> POP at now=30. diff=25>20 gives late_o=1; after handshake late_cnt_o=1.
- drop_valid_i=1, id=7 in the same cycle a head is due -> pq_op_o=DROP, pq_id_o=7, drop_ready_o=1. POP follows in the next cycle.
- out_ready_i=0 for 5 cycles in HOLD with a second head due -> no POP issued, out_cell_o unchanged. After the handshake, a bubble cycle, then POP.
- Preload now to 2**27-2, head data=2**27-1, tick across the wrap -> POP when now=2**27-1, and no POP issued after wrap to 0 for a head with data=100.
